// File: rtl/axis_pkg.sv
// Shared widths and the stored beat layout for the AXI-Stream FIFO.
package axis_pkg;
  localparam int WORD_W         = 8;
  localparam int BUS_W          = 32;
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W;

  typedef struct packed {
    logic [BUS_W-1:0]          data;
    logic [WORDS_PER_BEAT-1:0] keep;
    logic                      last;
  } beat_t;
endpackage

// File: rtl/axis_fifo_if.sv
// One AXI-Stream valid/ready link; master drives the beat, slave returns ready.
interface axis_fifo_if;
  import axis_pkg::*;

  logic                      valid;
  logic                      ready;
  logic [BUS_W-1:0]          data;
  logic [WORDS_PER_BEAT-1:0] keep;
  logic                      last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axis_fifo_mem.sv
// Beat storage: one synchronous write port, one asynchronous read port, no reset.
module axis_fifo_mem
  import axis_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  beat_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output beat_t             rdata
);
  beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO: beat visible the cycle after its push; s_ready = !full from registered state only.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward output with cut-through once the FIFO is full.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_fifo_if.slave             s,
  axis_fifo_if.master            m,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             rdy_en;
  logic             empty, full, push, pop;
  beat_t            wr_beat, rd_beat;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s.ready = rdy_en & ~full;
  assign push    = s.valid & s.ready;
  assign pop     = m.valid & m.ready;
  assign count   = wr_ptr - rd_ptr;

  // rdy_en keeps s_ready low until the first edge after reset releases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign wr_beat = '{data: s.data, keep: s.keep, last: s.last};

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wr_beat),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_beat)
  );

  assign m.data = rd_beat.data;
  assign m.keep = rd_beat.keep;
  assign m.last = rd_beat.last;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [PTR_W-1:0] pkt_cnt;
  logic             in_pkt;

  // in_pkt holds the output open once a packet has started leaving, so a
  // cut-through packet keeps draining after the FIFO drops below full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
      in_pkt  <= 1'b0;
    end else begin
      case ({push & s.last, pop & m.last})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PTR_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (pop) in_pkt <= ~m.last;
    end
  end

  assign m.valid = ~empty & ((pkt_cnt != '0) | full | in_pkt);
`else
  assign m.valid = ~empty;
`endif
endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: reset, FWFT latency, full/empty limits, concurrent push/pop, packet streams, async reset.
module tb_axis_fifo;
  import axis_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] count;
  int         checks = 0;
  int         passed = 0;

  axis_fifo_if s_if ();
  axis_fifo_if m_if ();

  axis_fifo #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .s    (s_if),
    .m    (m_if),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    s_if.valid = 1'b1; s_if.data = d; s_if.keep = 4'hF; s_if.last = l;
    step();
    s_if.valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (m_if.valid !== 1'b0) $display("FAIL rst_mvalid got=%b exp=0", m_if.valid); else passed++;
    checks++; if (count !== 5'd0) $display("FAIL rst_count got=%0d exp=0", count); else passed++;
    checks++; if (s_if.ready !== 1'b0) $display("FAIL rst_sready got=%b exp=0", s_if.ready); else passed++;
    step();
    rst = 1'b0;
    checks++; if (s_if.ready !== 1'b0) $display("FAIL rst_sready_pre_edge got=%b exp=0", s_if.ready); else passed++;
    step();
    checks++; if (s_if.ready !== 1'b1) $display("FAIL rst_sready_rise got=%b exp=1", s_if.ready); else passed++;
  endtask

  task automatic test_single;
    s_if.valid = 1'b1; s_if.data = 32'hDEADBEEF; s_if.keep = 4'hF; s_if.last = 1'b1; m_if.ready = 1'b1;
    checks++; if (m_if.valid !== 1'b0) $display("FAIL single_no_comb got=%b exp=0", m_if.valid); else passed++;
    step();
    s_if.valid = 1'b0;
    checks++; if (m_if.valid !== 1'b1) $display("FAIL single_mvalid got=%b exp=1", m_if.valid); else passed++;
    checks++; if (m_if.data !== 32'hDEADBEEF) $display("FAIL single_data got=%h exp=deadbeef", m_if.data); else passed++;
    checks++; if (m_if.keep !== 4'hF) $display("FAIL single_keep got=%h exp=f", m_if.keep); else passed++;
    checks++; if (m_if.last !== 1'b1) $display("FAIL single_last got=%b exp=1", m_if.last); else passed++;
    checks++; if (count !== 5'd1) $display("FAIL single_count1 got=%0d exp=1", count); else passed++;
    step();
    m_if.ready = 1'b0;
    checks++; if (m_if.valid !== 1'b0) $display("FAIL single_drained got=%b exp=0", m_if.valid); else passed++;
    checks++; if (count !== 5'd0) $display("FAIL single_count0 got=%0d exp=0", count); else passed++;
  endtask

  task automatic test_fill;
    m_if.ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (s_if.ready !== 1'b1) $display("FAIL fill_sready beat=%0d got=%b exp=1", i, s_if.ready); else passed++;
      push_beat(32'(i), i == DEPTH - 1);
    end
    checks++; if (s_if.ready !== 1'b0) $display("FAIL full_sready got=%b exp=0", s_if.ready); else passed++;
    checks++; if (count !== 5'd16) $display("FAIL full_count got=%0d exp=16", count); else passed++;
    checks++; if (m_if.data !== 32'd0) $display("FAIL full_head got=%0d exp=0", m_if.data); else passed++;
    // pop while full with a push offered: the push must be refused
    s_if.valid = 1'b1; s_if.data = 32'd99; s_if.last = 1'b1; m_if.ready = 1'b1;
    step();
    s_if.valid = 1'b0;
    checks++; if (count !== 5'd15) $display("FAIL full_pop_count got=%0d exp=15", count); else passed++;
    checks++; if (s_if.ready !== 1'b1) $display("FAIL full_pop_sready got=%b exp=1", s_if.ready); else passed++;
    for (int i = 1; i < DEPTH; i++) begin
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== 32'(i))
        $display("FAIL fill_order idx=%0d got v=%b d=%0d exp v=1 d=%0d", i, m_if.valid, m_if.data, i); else passed++;
      step();
    end
    m_if.ready = 1'b0;
    checks++; if (m_if.valid !== 1'b0) $display("FAIL fill_empty got=%b exp=0", m_if.valid); else passed++;
    checks++; if (count !== 5'd0) $display("FAIL fill_count0 got=%0d exp=0", count); else passed++;
  endtask

  task automatic test_simul;
    logic [31:0] q[$];
    logic [31:0] exp_d;
    m_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_beat(32'(100 + i), 1'b1);
      q.push_back(32'(100 + i));
    end
    for (int k = 0; k < 10; k++) begin
      s_if.valid = 1'b1; s_if.data = 32'(200 + k); s_if.last = 1'b1; m_if.ready = 1'b1;
      q.push_back(32'(200 + k));
      exp_d = q.pop_front();
      checks++; if (count !== 5'd5) $display("FAIL simul_count cyc=%0d got=%0d exp=5", k, count); else passed++;
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== exp_d)
        $display("FAIL simul_order cyc=%0d got v=%b d=%0d exp v=1 d=%0d", k, m_if.valid, m_if.data, exp_d); else passed++;
      step();
    end
    s_if.valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_d = q.pop_front();
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== exp_d)
        $display("FAIL simul_drain idx=%0d got v=%b d=%0d exp v=1 d=%0d", k, m_if.valid, m_if.data, exp_d); else passed++;
      step();
    end
    m_if.ready = 1'b0;
    checks++; if (count !== 5'd0) $display("FAIL simul_count0 got=%0d exp=0", count); else passed++;
  endtask

  task automatic test_packets;
    beat_t exp_q[$];
    beat_t b, got;
    int    n, nb, rem, sent, rcvd, cyc;
    logic  s_acc, m_acc;
    for (int p = 0; p < 20; p++) begin
      n   = $urandom_range(1, 100);
      nb  = (n + 3) / 4;
      rem = n % 4;
      for (int i = 0; i < nb; i++) begin
        b.data = $urandom;
        b.last = (i == nb - 1);
        b.keep = (b.last && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
        exp_q.push_back(b);
      end
    end
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < exp_q.size() && cyc < 20000) begin
      if (sent < exp_q.size()) begin
        s_if.valid = 1'b1; s_if.data = exp_q[sent].data; s_if.keep = exp_q[sent].keep; s_if.last = exp_q[sent].last;
      end else s_if.valid = 1'b0;
      m_if.ready = ($urandom_range(0, 9) == 0);
      s_acc = s_if.valid & s_if.ready;
      m_acc = m_if.valid & m_if.ready;
      if (m_acc) begin
        got = '{data: m_if.data, keep: m_if.keep, last: m_if.last};
        checks++; if (got !== exp_q[rcvd]) $display("FAIL pkt_beat idx=%0d got=%h exp=%h", rcvd, got, exp_q[rcvd]); else passed++;
        rcvd++;
      end
      if (s_acc) sent++;
      step();
      cyc++;
    end
    s_if.valid = 1'b0; m_if.ready = 1'b0;
    checks++; if (rcvd !== exp_q.size()) $display("FAIL pkt_timeout got=%0d beats exp=%0d", rcvd, exp_q.size()); else passed++;
  endtask

  task automatic test_async_reset;
    m_if.ready = 1'b0;
    for (int i = 0; i < 7; i++) push_beat(32'(300 + i), 1'b0);
    checks++; if (count !== 5'd7) $display("FAIL arst_pre_count got=%0d exp=7", count); else passed++;
    #3 rst = 1'b1;
    #1;
    checks++; if (m_if.valid !== 1'b0) $display("FAIL arst_mvalid got=%b exp=0", m_if.valid); else passed++;
    checks++; if (count !== 5'd0) $display("FAIL arst_count got=%0d exp=0", count); else passed++;
    checks++; if (s_if.ready !== 1'b0) $display("FAIL arst_sready got=%b exp=0", s_if.ready); else passed++;
    #2 rst = 1'b0;
    step();
    checks++; if (s_if.ready !== 1'b1) $display("FAIL arst_sready_rise got=%b exp=1", s_if.ready); else passed++;
    for (int i = 0; i < 3; i++) push_beat(32'(400 + i), i == 2);
    m_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== 32'(400 + i) || m_if.last !== (i == 2))
        $display("FAIL arst_fresh idx=%0d got v=%b d=%0d l=%b exp v=1 d=%0d", i, m_if.valid, m_if.data, m_if.last, 400 + i); else passed++;
      step();
    end
    m_if.ready = 1'b0;
    checks++; if (count !== 5'd0) $display("FAIL arst_fresh_count got=%0d exp=0", count); else passed++;
  endtask

`ifdef AXIS_FIFO_PACKET_MODE_EN
  task automatic test_pkt_mode;
    int          sent, rcvd, cyc, first_cnt;
    logic        s_acc, m_acc;
    m_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_beat(32'(500 + i), 1'b0);
      checks++; if (m_if.valid !== 1'b0) $display("FAIL pm_hold beat=%0d got=%b exp=0", i, m_if.valid); else passed++;
    end
    push_beat(32'd503, 1'b1);
    checks++; if (m_if.valid !== 1'b1) $display("FAIL pm_release got=%b exp=1", m_if.valid); else passed++;
    m_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== 32'(500 + i))
        $display("FAIL pm_drain idx=%0d got v=%b d=%0d exp v=1 d=%0d", i, m_if.valid, m_if.data, 500 + i); else passed++;
      step();
    end
    // 20-beat packet into 16 entries: output only opens when full
    sent = 0; rcvd = 0; cyc = 0; first_cnt = -1;
    while (rcvd < 20 && cyc < 500) begin
      s_if.valid = (sent < 20); s_if.data = 32'(600 + sent); s_if.keep = 4'hF; s_if.last = (sent == 19);
      s_acc = s_if.valid & s_if.ready;
      m_acc = m_if.valid & m_if.ready;
      if (m_acc) begin
        if (first_cnt < 0) first_cnt = int'(count);
        checks++; if (m_if.data !== 32'(600 + rcvd) || m_if.last !== (rcvd == 19))
          $display("FAIL pm_cut idx=%0d got d=%0d l=%b exp d=%0d", rcvd, m_if.data, m_if.last, 600 + rcvd); else passed++;
        rcvd++;
      end
      if (s_acc) sent++;
      step();
      cyc++;
    end
    s_if.valid = 1'b0; m_if.ready = 1'b0;
    checks++; if (rcvd !== 20) $display("FAIL pm_cut_timeout got=%0d beats exp=20", rcvd); else passed++;
    checks++; if (first_cnt !== 16) $display("FAIL pm_cut_open got=%0d exp=16", first_cnt); else passed++;
  endtask
`endif

  initial begin
    s_if.valid = 1'b0; s_if.data = '0; s_if.keep = '0; s_if.last = 1'b0;
    m_if.ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_packets();
    test_async_reset();
`ifdef AXIS_FIFO_PACKET_MODE_EN
    test_pkt_mode();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Synchronous AXI-Stream FIFO that buffers beats (data, keep, last) between an upstream producer and a downstream consumer.
- It sits directly between the stream source and stream sink in the bench. It is the first DUT stage on that path and absorbs the sink's random backpressure.
- Handshake on both sides is the standard valid/ready protocol.

Parameters:
- WORD_W, 8, bits per word.
- BUS_W, 32, bus width in bits; must be a multiple of WORD_W. WORDS_PER_BEAT = BUS_W/WORD_W.
- DEPTH, 16, beats of storage; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  FIFO can accept a beat.
- s_data  in  BUS_W  upstream data; word i occupies bits [i*WORD_W +: WORD_W].
- s_keep  in  WORDS_PER_BEAT  per-word byte-enable/keep.
- s_last  in  1  final beat of a packet.
- m_valid  out  1  a beat is presented downstream.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  BUS_W  downstream data.
- m_keep  out  WORDS_PER_BEAT  downstream keep.
- m_last  out  1  downstream last.
- count  out  $clog2(DEPTH)+1  beats currently stored.

Behaviour:
- Reset:
  - rst is asynchronous and active-high; assertion takes effect immediately, regardless of clk.
  - On reset: read/write pointers = 0, count = 0, m_valid = 0, s_ready = 0.
  - s_ready rises on the first clk edge after rst deasserts.
  - m_data, m_keep and m_last are don't-care while m_valid = 0.
- Reset mid-operation: all stored beats are discarded and no partial packet is emitted afterwards. Upstream must restart on a packet boundary.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs different.
  - Both pointers wrap from DEPTH*2-1 to 0.
- Flow control:
  - push = s_valid & s_ready; pop = m_valid & m_ready.
  - s_ready = !full. It is registered-state derived, with no combinational path from m_ready.
  - m_valid = !empty (in packet mode, see Optional Feature).
- Output is first-word-fall-through: m_data/m_keep/m_last show the entry at the read pointer through an asynchronous read.
- Latency: a beat pushed at edge N is visible on m_* with m_valid = 1 in the cycle after edge N. The minimum latency is one cycle and there is no combinational s->m path.
- Simultaneous push and pop:
  - Allowed whenever neither full nor empty blocks them; count is unchanged.
  - When empty, only a push is possible. When full, only a pop is possible (s_ready = 0). Full-with-pop does not accept a push in the same cycle.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Range is 0..DEPTH.
- Data integrity:
  - keep and last are stored verbatim per beat; no repacking.
  - A beat with keep = 0 is stored and forwarded unchanged.
- m_* fields hold stable while m_valid = 1 and m_ready = 0 (AXIS rule).

Optional Feature:
- Macro: AXIS_FIFO_PACKET_MODE_EN.
- Defined (store-and-forward):
  - A pkt_cnt counter is kept, sized $clog2(DEPTH)+1 bits. It increments on a push with s_last = 1 and decrements on a pop with m_last = 1; both in the same cycle leave it unchanged.
  - m_valid = !empty & (pkt_cnt != 0 | full). The full term is a cut-through fallback so that packets longer than DEPTH never deadlock.
  - Once the first beat of a packet has been popped, m_valid stays tied to !empty until that packet's m_last pops.
- Undefined: plain FIFO behaviour as described above, with no pkt_cnt logic.

Decomposition:
- Package axis_pkg holds WORD_W/BUS_W defaults, WORDS_PER_BEAT, and the beat struct typedef (data, keep, last) used for storage.
- One sub-module, axis_fifo_mem:
  - DEPTH x beat register array, one synchronous write port, one asynchronous read port, no reset on storage.
  - The top level owns pointers, flags, count and packet logic.

Test Plan:
- Reset then single beat: push data=0xDEADBEEF, keep=4'hF, last=1 with m_ready=1 -> m_valid rises the cycle after the push, m_data=0xDEADBEEF, m_last=1, count returns 0.
- Fill to full: m_ready=0, push 16 beats (data 0..15) -> s_ready=0 after the 16th, count=16. Then m_ready=1 -> beats pop in order 0..15, s_ready=1 after the first pop.
- Simultaneous push/pop at count=5 for 10 cycles -> count stays 5 and output order is preserved.
- Random 20 packets of 1-100 words: PROB_VALID=1, PROB_READY=10 source/sink -> every received packet equals the sent packet, including tail keep bits.
- Async reset asserted mid-packet at count=7 -> m_valid=0 and count=0 immediately, before the next edge. A fresh packet afterwards is received intact.
- AXIS_FIFO_PACKET_MODE_EN: push 3 beats without last -> m_valid stays 0; push the last beat -> m_valid=1 next cycle. A 20-beat packet with DEPTH=16 -> cut-through on full, all 20 beats delivered.
